// File: rtl/shift6_pkg.sv
// -----------------------------------------------------------------------------
// shift6_pkg
// Shared definitions for the shift6 serial shift-register sequencer:
//   - state_t      : controller state encoding (IDLE, SHIFT, DONE)
//   - SHIFT6_WIDTH : default shift word length
//   - SHIFT6_CNT_W : default bit-counter width (2**CNT_W > WIDTH)
//   - even_parity  : XOR reduction of a word of up to PARITY_MAX_W bits
// Optional build macro used by the design: SHIFT6_PARITY_EN
// -----------------------------------------------------------------------------
package shift6_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SHIFT6_WIDTH = 6;
  localparam int SHIFT6_CNT_W = 3;
  localparam int PARITY_MAX_W = 16;

  // Callers zero-extend narrower words; zero bits do not change the XOR.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/shift6_sreg.sv
// -----------------------------------------------------------------------------
// shift6_sreg
// Loadable left-shift register. Load has priority over shift; the bit shifted
// in at the LSB comes from ser_in, the MSB is the next bit to leave.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous reset, active-low (clears the register)
//   load   in   parallel load of d
//   shift  in   shift left by one, inserting ser_in
//   d      in   [WIDTH-1:0] parallel load data
//   ser_in in   serial input bit
//   q      out  [WIDTH-1:0] register contents
// -----------------------------------------------------------------------------
module shift6_sreg
  import shift6_pkg::*;
#(
  parameter int WIDTH = SHIFT6_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (shift) begin
      r_q <= {r_q[WIDTH-2:0], ser_in};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/shift6_ctrl.sv
// -----------------------------------------------------------------------------
// shift6_ctrl
// Sequencer for the serial shift-register datapath. Accepts a parallel word on
// a valid/ready handshake, shifts it out MSB first on ser_out while capturing
// the same number of bits from ser_in, then presents the captured word on
// rx_data with a one-cycle rx_valid pulse (in the DONE state).
// Build option: define SHIFT6_PARITY_EN to append one even-parity bit to each
// frame and add the rx_perr output (received parity check result).
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous reset, active-low
//   tx_data  in   [WIDTH-1:0] word to transmit
//   tx_valid in   tx_data valid
//   tx_ready out  word accepted this cycle if tx_valid (IDLE or DONE)
//   ser_out  out  serial data out, MSB first, 0 outside SHIFT
//   ser_in   in   serial data in, sampled during SHIFT
//   frame    out  high during SHIFT
//   rx_data  out  [WIDTH-1:0] last captured word, held between frames
//   rx_valid out  one-cycle pulse when rx_data has updated
//   busy     out  high whenever not IDLE
//   rx_perr  out  (SHIFT6_PARITY_EN only) parity error, valid with rx_valid
// -----------------------------------------------------------------------------
module shift6_ctrl
  import shift6_pkg::*;
#(
  parameter int WIDTH = SHIFT6_WIDTH,
  parameter int CNT_W = SHIFT6_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             frame,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
`ifdef SHIFT6_PARITY_EN
  ,
  output logic             rx_perr
`endif
);

  // Terminal count: the last SHIFT cycle of a frame.
`ifdef SHIFT6_PARITY_EN
  localparam int LAST_BIT = WIDTH;
`else
  localparam int LAST_BIT = WIDTH - 1;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_BIT);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rx_data;
  logic [WIDTH-1:0] w_q;
  logic             w_load;
  logic             w_shift;
  logic             w_last;

  assign w_last = (r_state == SHIFT) && (r_cnt == CNT_LAST);

  shift6_sreg #(
    .WIDTH (WIDTH)
  ) u_sreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .shift  (w_shift),
    .d      (tx_data),
    .ser_in (ser_in),
    .q      (w_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Cleared on every load, so it cannot wrap within a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef SHIFT6_PARITY_EN
  logic r_tx_par;
  logic r_rx_perr;

  // The shift register is empty of transmit data by the parity cycle, so the
  // parity of the outgoing word is captured at load time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_par <= 1'b0;
    end else if (w_load) begin
      r_tx_par <= even_parity(PARITY_MAX_W'(tx_data));
    end
  end

  // In the parity cycle the register already holds the received data bits;
  // ser_in carries the sender's parity bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_data <= '0;
      r_rx_perr <= 1'b0;
    end else if (w_last) begin
      r_rx_data <= w_q;
      r_rx_perr <= ser_in ^ even_parity(PARITY_MAX_W'(w_q));
    end
  end

  assign rx_perr = r_rx_perr;
`else
  // Capture the value the register takes at the final shift edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_data <= '0;
    end else if (w_last) begin
      r_rx_data <= {w_q[WIDTH-2:0], ser_in};
    end
  end
`endif

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    tx_ready     = 1'b0;
    frame        = 1'b0;
    ser_out      = 1'b0;
    rx_valid     = 1'b0;
    unique case (r_state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          w_load       = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        frame   = 1'b1;
        ser_out = w_q[WIDTH-1];
        w_shift = 1'b1;
`ifdef SHIFT6_PARITY_EN
        if (w_last) begin
          ser_out = r_tx_par;
          w_shift = 1'b0;
        end
`endif
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        rx_valid = 1'b1;
        tx_ready = 1'b1;
        if (tx_valid) begin
          w_load       = 1'b1;
          w_state_next = SHIFT;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign busy    = (r_state != IDLE);
  assign rx_data = r_rx_data;

endmodule

// File: tb/tb_shift6_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift6_ctrl
// Self-checking bench for shift6_ctrl (WIDTH=6). The expected serial stream is
// derived arithmetically from the word (MSB first, parity last when
// SHIFT6_PARITY_EN is defined) and the expected received word is assembled
// from the bits the bench itself places on ser_in.
// -----------------------------------------------------------------------------
module tb_shift6_ctrl;

  localparam int W = 6;
`ifdef SHIFT6_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data  = '0;
  logic         ser_drv  = 1'b0;
  bit           loop_en  = 1'b0;
  logic         ser_in;
  logic         tx_ready;
  logic         ser_out;
  logic         frame;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
`ifdef SHIFT6_PARITY_EN
  logic         rx_perr;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  assign ser_in = loop_en ? ser_out : ser_drv;

  shift6_ctrl #(
    .WIDTH (W),
    .CNT_W (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .ser_out  (ser_out),
    .ser_in   (ser_in),
    .frame    (frame),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
`ifdef SHIFT6_PARITY_EN
    ,
    .rx_perr  (rx_perr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bit expected on the wire at frame position i: data MSB first, then parity.
  function automatic logic model_bit(input logic [W-1:0] word, input int i);
    int v;
    v = int'(word);
    if (i < W) return ((v / (1 << (W - 1 - i))) % 2) == 1;
    return ^word;
  endfunction

  // First received bit ends up as the MSB of the word.
  function automatic logic [W-1:0] pack_bits(input logic b[$]);
    int v;
    v = 0;
    foreach (b[i]) v = v * 2 + int'(b[i]);
    return W'(v);
  endfunction

  // Presents word in an accepting cycle (IDLE or DONE), runs the frame and
  // checks every shift cycle plus the DONE cycle. poke: shift index at which a
  // stray 6'h3F request is made; abort: shift index at which reset is pulsed.
  task automatic run_frame(input logic [W-1:0] word, input logic [FLEN-1:0] bits,
                           input bit keep, input logic [W-1:0] next_word,
                           input int poke, input int abort, input string tag,
                           output int done_cyc, output logic [W-1:0] exp_rx);
    logic q[$];
    logic rb;
    logic par_in;
    logic exp_bit;
    par_in   = 1'b0;
    done_cyc = -1;
    exp_rx   = '0;
    tx_data  = word;
    tx_valid = 1'b1;
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept_ready: got %b want 1", tag, tx_ready);
    end
    tick;
    if (keep) tx_data = next_word;
    else tx_valid = 1'b0;
    for (int i = 0; i < FLEN; i++) begin
      if (i == abort) begin
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        return;
      end
      if (i == poke) begin
        tx_valid = 1'b1;
        tx_data  = 6'h3F;
      end
      exp_bit = model_bit(word, i);
      ser_drv = bits[i];
      rb      = loop_en ? exp_bit : bits[i];
      if (i < W) q.push_back(rb);
      else par_in = rb;
      n_checks += 5;
      if (frame !== 1'b1) begin
        n_fail++;
        $display("FAIL %s frame bit%0d: got %b want 1", tag, i, frame);
      end
      if (tx_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s shift_ready bit%0d: got %b want 0", tag, i, tx_ready);
      end
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s shift_busy bit%0d: got %b want 1", tag, i, busy);
      end
      if (rx_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s early_rx_valid bit%0d: got %b want 0", tag, i, rx_valid);
      end
      if (ser_out !== exp_bit) begin
        n_fail++;
        $display("FAIL %s ser_out bit%0d: got %b want %b", tag, i, ser_out, exp_bit);
      end
      tick;
      if (i == poke) begin
        tx_valid = 1'b0;
        tx_data  = word;
      end
    end
    exp_rx = pack_bits(q);
    n_checks += 5;
    if (rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s rx_valid: got %b want 1", tag, rx_valid);
    end
    if (rx_data !== exp_rx) begin
      n_fail++;
      $display("FAIL %s rx_data: got %h want %h", tag, rx_data, exp_rx);
    end
    if (frame !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_frame: got %b want 0", tag, frame);
    end
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_ready: got %b want 1", tag, tx_ready);
    end
    if (ser_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_ser_out: got %b want 0", tag, ser_out);
    end
`ifdef SHIFT6_PARITY_EN
    n_checks++;
    if (rx_perr !== (par_in ^ (^exp_rx))) begin
      n_fail++;
      $display("FAIL %s rx_perr: got %b want %b", tag, rx_perr, par_in ^ (^exp_rx));
    end
`endif
    done_cyc = cyc;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    n_checks += 6;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset tx_ready: got %b want 1", tx_ready); end
    if (frame !== 1'b0) begin n_fail++; $display("FAIL reset frame: got %b want 0", frame); end
    if (ser_out !== 1'b0) begin n_fail++; $display("FAIL reset ser_out: got %b want 0", ser_out); end
    if (rx_data !== '0) begin n_fail++; $display("FAIL reset rx_data: got %h want 00", rx_data); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset rx_valid: got %b want 0", rx_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_loopback;
    int dc;
    logic [W-1:0] er;
    loop_en = 1'b1;
    run_frame(6'b101101, '0, 1'b0, '0, -1, -1, "loopback", dc, er);
    n_checks++;
    if (rx_data !== 6'b101101) begin
      n_fail++;
      $display("FAIL loopback word: got %b want 101101", rx_data);
    end
    tick;
    n_checks += 2;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL loopback pulse_len: got %b want 0", rx_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL loopback idle_busy: got %b want 0", busy); end
    loop_en = 1'b0;
  endtask

  task automatic test_constant;
    int dc;
    logic [W-1:0] er;
    run_frame(6'b000000, '1, 1'b0, '0, -1, -1, "constant", dc, er);
    n_checks++;
    if (rx_data !== 6'b111111) begin
      n_fail++;
      $display("FAIL constant word: got %b want 111111", rx_data);
    end
    tick;
  endtask

  task automatic test_random;
    int dc;
    int gap;
    logic [W-1:0] er;
    logic [W-1:0] w;
    logic [FLEN-1:0] b;
    for (int n = 0; n < 12; n++) begin
      w = W'($urandom);
      b = FLEN'($urandom);
      run_frame(w, b, 1'b0, '0, -1, -1, "random", dc, er);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick;
        n_checks += 3;
        if (rx_data !== er) begin n_fail++; $display("FAIL random hold: got %h want %h", rx_data, er); end
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL random idle_valid: got %b want 0", rx_valid); end
        if (ser_out !== 1'b0) begin n_fail++; $display("FAIL random idle_ser_out: got %b want 0", ser_out); end
      end
    end
    tick;
  endtask

  task automatic test_back_to_back;
    int c1;
    int c2;
    logic [W-1:0] er;
    loop_en = 1'b1;
    run_frame(6'h2A, '0, 1'b1, 6'h15, -1, -1, "b2b_first", c1, er);
    n_checks++;
    if (rx_data !== 6'h2A) begin n_fail++; $display("FAIL b2b first_word: got %h want 2a", rx_data); end
    run_frame(6'h15, '0, 1'b0, '0, -1, -1, "b2b_second", c2, er);
    n_checks += 2;
    if (rx_data !== 6'h15) begin n_fail++; $display("FAIL b2b second_word: got %h want 15", rx_data); end
    if (c2 - c1 !== FLEN + 1) begin
      n_fail++;
      $display("FAIL b2b pulse_spacing: got %0d want %0d", c2 - c1, FLEN + 1);
    end
    tick;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b idle_busy: got %b want 0", busy); end
    loop_en = 1'b0;
  endtask

  task automatic test_busy_reject;
    int dc;
    int seen;
    logic [W-1:0] er;
    run_frame(6'b010011, FLEN'(6'b100110), 1'b0, '0, 2, -1, "busy_reject", dc, er);
    seen = 0;
    for (int g = 0; g < 10; g++) begin
      tick;
      if (frame === 1'b1 || busy === 1'b1 || rx_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL busy_reject extra_frame: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_reset_mid;
    int dc;
    int seen;
    logic [W-1:0] er;
    run_frame(6'h2A, '1, 1'b0, '0, -1, 3, "reset_mid", dc, er);
    n_checks += 6;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy: got %b want 0", busy); end
    if (frame !== 1'b0) begin n_fail++; $display("FAIL reset_mid frame: got %b want 0", frame); end
    if (ser_out !== 1'b0) begin n_fail++; $display("FAIL reset_mid ser_out: got %b want 0", ser_out); end
    if (rx_data !== '0) begin n_fail++; $display("FAIL reset_mid rx_data: got %h want 00", rx_data); end
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid tx_ready: got %b want 1", tx_ready); end
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid rx_valid: got %b want 0", rx_valid); end
    seen = 0;
    for (int g = 0; g < 10; g++) begin
      tick;
      if (rx_valid === 1'b1 || frame === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_mid late_activity: got %0d cycles want 0", seen);
    end
  endtask

`ifdef SHIFT6_PARITY_EN
  task automatic test_parity;
    int dc;
    logic [W-1:0] er;
    logic [FLEN-1:0] b;
    loop_en = 1'b1;
    run_frame(6'b101100, '0, 1'b0, '0, -1, -1, "parity_ok", dc, er);
    n_checks++;
    if (rx_perr !== 1'b0) begin n_fail++; $display("FAIL parity_ok perr: got %b want 0", rx_perr); end
    tick;
    loop_en = 1'b0;
    for (int i = 0; i < W; i++) b[i] = model_bit(6'b101100, i);
    b[W] = 1'b0;
    run_frame(6'b101100, b, 1'b0, '0, -1, -1, "parity_bad", dc, er);
    n_checks += 2;
    if (rx_perr !== 1'b1) begin n_fail++; $display("FAIL parity_bad perr: got %b want 1", rx_perr); end
    if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL parity_bad valid: got %b want 1", rx_valid); end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_loopback;
    test_constant;
    test_random;
    test_back_to_back;
    test_busy_reject;
    test_reset_mid;
`ifdef SHIFT6_PARITY_EN
    test_parity;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
